ins_fetch_unit: RTL

Parametrised instruction memory with a sequenced loader and a handshaked fetch port; successor to the fixed 16-bit/64-byte instruction memory. Words are loaded as a burst from an auto-incrementing pointer, and fetches are refused until a load completes. It sits between the program loader and the PC/decode stage of the processor.

---
 rtl/ins_fetch_pkg.sv | 16 +
 rtl/ins_fetch_unit_if.sv | 30 +++
 rtl/ins_byte_ram.sv | 55 +++++
 rtl/ins_fetch_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: shared types and helpers for the instruction fetch unit.
//   state_e  - load/fetch sequencer states
//   calc_bpi - bytes per instruction word
package ins_fetch_pkg;

   typedef enum logic [1:0] {
      StEmpty,
      StLoading,
      StReady
   } state_e;

   function automatic int unsigned calc_bpi(input int unsigned ins_w, input int unsigned byte_w);
      return ins_w / byte_w;
   endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// ins_fetch_unit_if: loader and fetch bus of the instruction fetch unit.
//   master - program loader / PC stage side (drives requests, receives results)
//   slave  - the fetch unit itself
interface ins_fetch_unit_if #(
   parameter int unsigned INS_W  = 16,
   parameter int unsigned ADDR_W = 6
);
   logic              load_start;
   logic [ADDR_W-1:0] l_addr;
   logic              load;
   logic [INS_W-1:0]  ins_load;
   logic              load_done;
   logic              fetch;
   logic [ADDR_W-1:0] pc_addr;
   logic [INS_W-1:0]  ins_out;
   logic              ins_valid;
   logic              fetch_err;
   logic              mem_ready;
   logic              load_full;

   modport master (
      output load_start, l_addr, load, ins_load, load_done, fetch, pc_addr,
      input  ins_out, ins_valid, fetch_err, mem_ready, load_full
   );

   modport slave (
      input  load_start, l_addr, load, ins_load, load_done, fetch, pc_addr,
      output ins_out, ins_valid, fetch_err, mem_ready, load_full
   );
endinterface

// File: rtl/ins_byte_ram.sv
// ins_byte_ram: byte-addressed storage with a BPI-byte write port and a
// BPI-byte registered read port; both ports wrap each byte address mod DEPTH.
//   clk_i, rst_i - clock, synchronous reset (read register only, not the array)
//   we_i, waddr_i, wdata_i - big-endian word write at any byte address
//   re_i, raddr_i          - read request; rdata_o updates the next cycle
//   rdata_o                - last read word, held when re_i is low
module ins_byte_ram #(
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned BPI    = 2,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned WORD_W = BPI * BYTE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q, rdata_d;

   // ADDR_W-bit adds wrap for free since DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int k = 0; k < BPI; k++) begin
            mem_q[waddr_i + ADDR_W'(k)] <= wdata_i[WORD_W-1-k*BYTE_W -: BYTE_W];
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         for (int k = 0; k < BPI; k++) begin
            rdata_d[WORD_W-1-k*BYTE_W -: BYTE_W] = mem_q[raddr_i + ADDR_W'(k)];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: instruction memory with a burst loader and a one-cycle fetch port.
//   clock - sole clock, posedge
//   reset - synchronous, active-high; memory contents survive it
//   bus   - slave side of ins_fetch_unit_if (load burst in, fetch request/result)
module ins_fetch_unit
   import ins_fetch_pkg::*;
#(
   parameter int unsigned INS_W  = 16,
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned DEPTH  = 64
) (
   input logic               clock,
   input logic               reset,
   ins_fetch_unit_if.slave   bus
);

   localparam int unsigned BPI    = calc_bpi(INS_W, BYTE_W);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PtrStep = ADDR_W'(BPI);
   localparam logic [CNT_W-1:0]  CntStep = CNT_W'(BPI);
   localparam logic [CNT_W-1:0]  CntFull = CNT_W'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_sum;
   logic              ins_valid_q, ins_valid_d;
   logic              fetch_err_q, fetch_err_d;
   logic              load_full;
   logic              we, re;

   assign load_full = (cnt_q == CntFull);
   assign cnt_sum   = cnt_q + CntStep;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      we          = 1'b0;
      re          = 1'b0;
      ins_valid_d = 1'b0;
      fetch_err_d = 1'b0;

      unique case (state_q)
         StEmpty, StReady: begin
            if (bus.load_start) begin
               state_d = StLoading;
               ptr_d   = bus.l_addr;
               cnt_d   = '0;
            end
         end
         StLoading: begin
            // A restart wins over both the write and load_done in the same cycle.
            if (bus.load_start) begin
               ptr_d = bus.l_addr;
               cnt_d = '0;
            end else begin
               if (bus.load && !load_full) begin
                  we    = 1'b1;
                  ptr_d = ptr_q + PtrStep;
                  cnt_d = (cnt_sum >= CntFull) ? CntFull : cnt_sum;
               end
               if (bus.load_done) begin
                  state_d = StReady;
               end
            end
         end
         default: state_d = StEmpty;
      endcase

      if (bus.fetch) begin
         if (state_q == StReady) begin
            re          = 1'b1;
            ins_valid_d = 1'b1;
         end else begin
            fetch_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StEmpty;
         ptr_q       <= '0;
         cnt_q       <= '0;
         ins_valid_q <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         ins_valid_q <= ins_valid_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // The RAM read register doubles as ins_out: it only updates on an accepted fetch.
   ins_byte_ram #(
      .BYTE_W (BYTE_W),
      .BPI    (BPI),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk_i   (clock),
      .rst_i   (reset),
      .we_i    (we),
      .waddr_i (ptr_q),
      .wdata_i (bus.ins_load),
      .re_i    (re),
      .raddr_i (bus.pc_addr),
      .rdata_o (bus.ins_out)
   );

   assign bus.ins_valid = ins_valid_q;
   assign bus.fetch_err = fetch_err_q;
   assign bus.mem_ready = (state_q == StReady);
   assign bus.load_full = load_full;

endmodule
